// File: rtl/aib_bringup_pkg.sv
// rtl/aib_bringup_pkg.sv - shared types and constants for the AIB link bring-up sequencer
package aib_bringup_pkg;

    localparam int AVMM_ADDR_W = 17;
    localparam int AVMM_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CFG       = 3'd1,
        ST_RST_HOLD  = 3'd2,
        ST_WAIT_LINK = 3'd3,
        ST_LINK_UP   = 3'd4,
        ST_FAIL      = 3'd5
    } state_e;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_AVMM_TO   = 2'd1;
    localparam logic [1:0] ERR_LINK_TO   = 2'd2;
    localparam logic [1:0] ERR_LINK_DROP = 2'd3;

endpackage

// File: rtl/aib_sync_2ff.sv
// rtl/aib_sync_2ff.sv - two-flop synchronizer bank for asynchronous link status bits
module aib_sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/aib_link_bringup_ctrl.sv
// rtl/aib_link_bringup_ctrl.sv - AVMM config writes, adapter reset / MAC-ready release, link wait and drop monitor
module aib_link_bringup_ctrl
    import aib_bringup_pkg::*;
#(
    parameter int                   NBR_CHNLS    = 24,
    parameter int                   ACTIVE_CHNLS = 1,
    parameter int                   NUM_CFG      = 4,
    parameter int                   RST_HOLD     = 16,
    parameter int                   TIMEOUT_W    = 20,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT      = 20'hFFFFF
) (
    input  logic                           avmm_clk,
    input  logic                           avmm_rst_n,
    input  logic                           start,
    input  logic                           stop,
    input  logic [NUM_CFG*AVMM_ADDR_W-1:0] cfg_addr,
    input  logic [NUM_CFG*AVMM_DATA_W-1:0] cfg_wdata,
    output logic [AVMM_ADDR_W-1:0]         o_avmm_addr,
    output logic [3:0]                     o_avmm_byte_en,
    output logic                           o_avmm_write,
    output logic [AVMM_DATA_W-1:0]         o_avmm_wdata,
    input  logic                           i_avmm_waitreq,
    output logic [NBR_CHNLS-1:0]           ns_adapter_rstn,
    output logic [NBR_CHNLS-1:0]           ns_mac_rdy,
    input  logic [NBR_CHNLS-1:0]           fs_mac_rdy,
    input  logic [NBR_CHNLS-1:0]           m_rx_align_done,
    input  logic [NBR_CHNLS-1:0]           ms_tx_transfer_en,
    input  logic [NBR_CHNLS-1:0]           sl_tx_transfer_en,
    output logic                           axi_rst_n,
    output logic                           link_up,
    output logic [1:0]                     err_code,
    output logic [2:0]                     state_dbg
);

    localparam int IDX_W = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_CFG - 1);
    localparam logic [TIMEOUT_W-1:0] HOLD_LAST = TIMEOUT_W'(RST_HOLD - 1);

    function automatic logic [NBR_CHNLS-1:0] gen_active_mask();
        logic [NBR_CHNLS-1:0] m;
        m = '0;
        for (int i = 0; i < ACTIVE_CHNLS; i++) m[i] = 1'b1;
        return m;
    endfunction

    localparam logic [NBR_CHNLS-1:0] ACT_MASK = gen_active_mask();

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [TIMEOUT_W-1:0]     timer_q, timer_d;
    logic                     write_q, write_d;
    logic [AVMM_ADDR_W-1:0]   addr_q, addr_d;
    logic [AVMM_DATA_W-1:0]   wdata_q, wdata_d;
    logic [NBR_CHNLS-1:0]     rstn_q, rstn_d;
    logic [NBR_CHNLS-1:0]     macrdy_q, macrdy_d;
    logic                     axi_rstn_q, axi_rstn_d;
    logic                     link_up_q, link_up_d;
    logic [1:0]               err_q, err_d;

    logic [4*NBR_CHNLS-1:0]   status_raw;
    logic [4*NBR_CHNLS-1:0]   status_s;
    logic                     link_ok;
    logic                     accept;
    logic [IDX_W-1:0]         idx_inc;
    logic [AVMM_ADDR_W-1:0]   nxt_addr;
    logic [AVMM_DATA_W-1:0]   nxt_wdata;
    logic                     go_idle, go_cfg, go_fail;
    logic [1:0]               fail_err;

    assign status_raw = {sl_tx_transfer_en, ms_tx_transfer_en, m_rx_align_done, fs_mac_rdy};

    aib_sync_2ff #(
        .WIDTH(4 * NBR_CHNLS)
    ) u_status_sync (
        .clk  (avmm_clk),
        .rst_n(avmm_rst_n),
        .d_i  (status_raw),
        .q_o  (status_s)
    );

    // Inactive channels are forced to 1 so they never gate link-up or cause a drop.
    assign link_ok = &(status_s | {4{~ACT_MASK}});
    assign accept  = write_q & ~i_avmm_waitreq;
    assign idx_inc = idx_q + 1'b1;

    always_comb begin
        nxt_addr  = '0;
        nxt_wdata = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (idx_inc == IDX_W'(i)) begin
                nxt_addr  = cfg_addr[AVMM_ADDR_W*i +: AVMM_ADDR_W];
                nxt_wdata = cfg_wdata[AVMM_DATA_W*i +: AVMM_DATA_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rstn_d     = rstn_q;
        macrdy_d   = macrdy_q;
        axi_rstn_d = axi_rstn_q;
        link_up_d  = link_up_q;
        err_d      = err_q;
        go_idle    = 1'b0;
        go_cfg     = 1'b0;
        go_fail    = 1'b0;
        fail_err   = ERR_NONE;

        if (stop) begin
            go_idle = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_FAIL: begin
                    go_cfg = start;
                end
                ST_CFG: begin
                    if (accept) begin
                        timer_d = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_RST_HOLD;
                            write_d = 1'b0;
                            addr_d  = '0;
                            wdata_d = '0;
                            rstn_d  = ACT_MASK;
                        end else begin
                            idx_d   = idx_inc;
                            addr_d  = nxt_addr;
                            wdata_d = nxt_wdata;
                        end
                    end else if (timer_q == TIMEOUT) begin
                        go_fail  = 1'b1;
                        fail_err = ERR_AVMM_TO;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_RST_HOLD: begin
                    if (timer_q == HOLD_LAST) begin
                        state_d  = ST_WAIT_LINK;
                        macrdy_d = ACT_MASK;
                        timer_d  = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_WAIT_LINK: begin
                    if (link_ok) begin
                        state_d    = ST_LINK_UP;
                        link_up_d  = 1'b1;
                        axi_rstn_d = 1'b1;
                        timer_d    = '0;
                    end else if (timer_q == TIMEOUT) begin
                        go_fail  = 1'b1;
                        fail_err = ERR_LINK_TO;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_LINK_UP: begin
                    if (!link_ok) begin
                        go_fail  = 1'b1;
                        fail_err = ERR_LINK_DROP;
                    end
                end
                default: go_idle = 1'b1;
            endcase
        end

        if (go_idle || go_fail) begin
            idx_d      = '0;
            timer_d    = '0;
            write_d    = 1'b0;
            addr_d     = '0;
            wdata_d    = '0;
            rstn_d     = '0;
            macrdy_d   = '0;
            axi_rstn_d = 1'b0;
            link_up_d  = 1'b0;
        end
        if (go_idle) begin
            state_d = ST_IDLE;
            err_d   = ERR_NONE;
        end
        if (go_fail) begin
            state_d = ST_FAIL;
            err_d   = fail_err;
        end
        if (go_cfg) begin
            state_d = ST_CFG;
            idx_d   = '0;
            timer_d = '0;
            err_d   = ERR_NONE;
            write_d = 1'b1;
            addr_d  = cfg_addr[AVMM_ADDR_W-1:0];
            wdata_d = cfg_wdata[AVMM_DATA_W-1:0];
        end
    end

    always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
        if (!avmm_rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            timer_q    <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rstn_q     <= '0;
            macrdy_q   <= '0;
            axi_rstn_q <= 1'b0;
            link_up_q  <= 1'b0;
            err_q      <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rstn_q     <= rstn_d;
            macrdy_q   <= macrdy_d;
            axi_rstn_q <= axi_rstn_d;
            link_up_q  <= link_up_d;
            err_q      <= err_d;
        end
    end

    assign o_avmm_addr     = addr_q;
    assign o_avmm_byte_en  = {4{write_q}};
    assign o_avmm_write    = write_q;
    assign o_avmm_wdata    = wdata_q;
    assign ns_adapter_rstn = rstn_q;
    assign ns_mac_rdy      = macrdy_q;
    assign axi_rst_n       = axi_rstn_q;
    assign link_up         = link_up_q;
    assign err_code        = err_q;
    assign state_dbg       = state_q;

endmodule
